// File: rtl/hififo_pio_regs.sv
// PIO register bank: ID, STATUS(W1C), ENABLE, HOLDOFF, SCRATCH, COUNTER,
// 1-cycle read completion, and a holdoff-paced interrupt pulse generator.
// Ports: clock/reset (async, active-high); wr_valid/wr_data/address/rr_valid
// in from the RX decoder; irq_src levels; rc_done/rc_data to the TX path;
// interrupt_out pulse to the PCIe core; int_status debug view.
module hififo_pio_regs #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [12:0] BASE_ADDR = 13'd0,
  parameter logic [63:0] ID_VALUE  = 64'd257
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [63:0]        wr_data,
  input  logic [12:0]        address,
  input  logic               rr_valid,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               rc_done,
  output logic [63:0]        rc_data,
  output logic               interrupt_out,
  output logic [NUM_IRQ-1:0] int_status
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [15:0]        hold_q, hold_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [63:0]        scratch_q, scratch_d;
  logic [63:0]        counter_q, counter_d;
  logic [63:0]        rc_data_q, rc_data_d;
  logic               rc_done_q;
  logic               irq_q, irq_d;

  logic               hit;
  logic [2:0]         off;
  logic               wr_hit;
  logic [NUM_IRQ-1:0] w1c;
  logic               pending;
  logic [63:0]        rd_val;

  assign hit     = (address[12:3] == BASE_ADDR[12:3]);
  assign off     = address[2:0];
  assign wr_hit  = wr_valid & hit;
  assign pending = |(status_q & enable_q);

  assign w1c = (wr_hit && off == 3'd1) ? wr_data[NUM_IRQ-1:0]
                                       : '0;

  // Register writes; a fresh source level wins over W1C.
  always_comb begin
    status_d  = irq_src | (status_q & ~w1c);
    enable_d  = enable_q;
    hold_d    = hold_q;
    scratch_d = scratch_q;
    counter_d = counter_q + 64'd1;
    if (wr_hit) begin
      unique case (off)
        3'd2:    enable_d  = wr_data[NUM_IRQ-1:0];
        3'd3:    hold_d    = wr_data[15:0];
        3'd4:    scratch_d = wr_data;
        3'd5:    counter_d = wr_data;
        default: ;
      endcase
    end
  end

  // Read mux sees pre-update register values.
  always_comb begin
    rd_val = '0;
    if (hit) begin
      unique case (off)
        3'd0:    rd_val = ID_VALUE;
        3'd1:    rd_val = 64'(status_q);
        3'd2:    rd_val = 64'(enable_q);
        3'd3:    rd_val = 64'(hold_q);
        3'd4:    rd_val = scratch_q;
        3'd5:    rd_val = counter_q;
        default: rd_val = '0;
      endcase
    end
  end

  assign rc_data_d = rr_valid ? rd_val : rc_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q  <= '0;
      enable_q  <= '0;
      hold_q    <= '0;
      scratch_q <= '0;
      counter_q <= '0;
      rc_data_q <= '0;
      rc_done_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      enable_q  <= enable_d;
      hold_q    <= hold_d;
      scratch_q <= scratch_d;
      counter_q <= counter_d;
      rc_data_q <= rc_data_d;
      rc_done_q <= rr_valid;
    end
  end

  // Interrupt FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  // Interrupt FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pending) begin
          state_d = S_HOLD;
          cnt_d   = hold_q;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'd0) state_d = S_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt FSM: output (registered one-cycle pulse)
  always_comb begin
    irq_d = 1'b0;
    if (state_q == S_IDLE && pending) irq_d = 1'b1;
  end

  assign rc_done       = rc_done_q;
  assign rc_data       = rc_data_q;
  assign interrupt_out = irq_q;
  assign int_status    = status_q;

endmodule

// File: tb/tb_hififo_pio_regs.sv
// Self-checking bench for hififo_pio_regs: directed steps plus random
// traffic compared each cycle against a behavioural model.
module tb_hififo_pio_regs;

  localparam int          N    = 8;
  localparam logic [12:0] BASE = 13'd0;
  localparam logic [63:0] IDV  = 64'd257;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [63:0]   wr_data = '0;
  logic [12:0]   address = '0;
  logic          rr_valid = 1'b0;
  logic [N-1:0]  irq_src = '0;
  logic          rc_done;
  logic [63:0]   rc_data;
  logic          interrupt_out;
  logic [N-1:0]  int_status;

  hififo_pio_regs #(
    .NUM_IRQ  (N),
    .BASE_ADDR(BASE),
    .ID_VALUE (IDV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .address      (address),
    .rr_valid     (rr_valid),
    .irq_src      (irq_src),
    .rc_done      (rc_done),
    .rc_data      (rc_data),
    .interrupt_out(interrupt_out),
    .int_status   (int_status)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [N-1:0] m_status;
  logic [N-1:0] m_enable;
  logic [15:0]  m_hold;
  logic [63:0]  m_scratch;
  logic [63:0]  m_cbase;
  logic [63:0]  m_cedge;
  logic [63:0]  m_next_ok;
  logic [63:0]  m_rc;
  logic [63:0]  cyc = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ad(input int o);
    return BASE | 13'(o);
  endfunction

  function automatic logic [63:0] m_read(input logic [12:0] a);
    if (a[12:3] != BASE[12:3]) return 64'd0;
    case (a[2:0])
      3'd0:    return IDV;
      3'd1:    return 64'(m_status);
      3'd2:    return 64'(m_enable);
      3'd3:    return 64'(m_hold);
      3'd4:    return m_scratch;
      3'd5:    return m_cbase + (cyc - m_cedge);
      default: return 64'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_status  = '0;
    m_enable  = '0;
    m_hold    = '0;
    m_scratch = '0;
    m_cbase   = '0;
    m_cedge   = cyc;
    m_next_ok = '0;
    m_rc      = '0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input logic wv, input logic rv,
                      input logic [12:0] a, input logic [63:0] wd,
                      input logic [N-1:0] irq);
    logic [63:0]  rd;
    logic         pend;
    logic         pulse;
    logic         hitw;
    logic [N-1:0] clr;
    wr_valid = wv;
    rr_valid = rv;
    address  = a;
    wr_data  = wd;
    irq_src  = irq;
    rd   = m_read(a);
    pend = |(m_status & m_enable);
    @(posedge clock);
    #1;
    cyc++;
    pulse = pend && (cyc >= m_next_ok);
    if (pulse) m_next_ok = cyc + 64'(m_hold) + 64'd2;
    if (rv) m_rc = rd;
    hitw = wv && (a[12:3] == BASE[12:3]);
    clr  = (hitw && a[2:0] == 3'd1) ? wd[N-1:0] : '0;
    m_status = irq | (m_status & ~clr);
    if (hitw) begin
      case (a[2:0])
        3'd2: m_enable  = wd[N-1:0];
        3'd3: m_hold    = wd[15:0];
        3'd4: m_scratch = wd;
        3'd5: begin
          m_cbase = wd;
          m_cedge = cyc;
        end
        default: ;
      endcase
    end
    wr_valid = 1'b0;
    rr_valid = 1'b0;
    irq_src  = '0;
    chk("rc_done", 64'(rc_done), 64'(rv));
    chk("rc_data", rc_data, m_rc);
    chk("irq_out", 64'(interrupt_out), 64'(pulse));
    chk("status", 64'(int_status), 64'(m_status));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          np;
    logic [63:0] p1, p2;
    logic        found;
    logic [12:0] ra;
    logic [63:0] rw;
    int          o;

    // reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
    chk("rst_done", 64'(rc_done), 64'd0);
    chk("rst_data", rc_data, 64'd0);
    chk("rst_irq", 64'(interrupt_out), 64'd0);
    chk("rst_status", 64'(int_status), 64'd0);

    // back-to-back reads of every offset
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, ad(i), 64'd0, '0);
      if (i == 0) chk("id_value", rc_data, 64'd257);
    end

    // scratch and out-of-window accesses
    step(1'b1, 1'b0, ad(4), 64'hDEAD_BEEF_0123_4567, '0);
    step(1'b0, 1'b1, ad(4), 64'd0, '0);
    chk("scratch", rc_data, 64'hDEAD_BEEF_0123_4567);
    step(1'b1, 1'b0, 13'h0008 | 13'd4, 64'h1111, '0);
    step(1'b0, 1'b1, 13'h0008 | 13'd4, 64'd0, '0);
    chk("miss_rd", rc_data, 64'd0);
    step(1'b0, 1'b1, ad(4), 64'd0, '0);
    chk("scratch_kept", rc_data, 64'hDEAD_BEEF_0123_4567);

    // simultaneous write/read returns old value
    step(1'b1, 1'b1, ad(4), 64'h5555, '0);
    chk("rw_same", rc_data, 64'hDEAD_BEEF_0123_4567);

    // interrupt period with holdoff 3
    step(1'b1, 1'b0, ad(2), 64'h1, '0);
    step(1'b1, 1'b0, ad(3), 64'd3, '0);
    step(1'b0, 1'b0, ad(0), 64'd0, 8'h01);
    np = 0;
    p1 = '0;
    p2 = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, ad(0), 64'd0, '0);
      if (interrupt_out) begin
        np++;
        if (np == 1) p1 = cyc;
        if (np == 2) p2 = cyc;
      end
    end
    chk("irq_count", 64'(np), 64'd3);
    chk("irq_period", p2 - p1, 64'd5);
    step(1'b1, 1'b0, ad(1), 64'h1, '0);
    np = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, ad(0), 64'd0, '0);
      if (interrupt_out) np++;
    end
    chk("irq_after_clr", 64'(np), 64'd0);

    // set beats W1C in same cycle; disable keeps status readable
    step(1'b1, 1'b0, ad(1), 64'h4, 8'h04);
    chk("set_wins", 64'(int_status[2]), 64'd1);
    step(1'b1, 1'b0, ad(2), 64'h0, '0);
    step(1'b0, 1'b1, ad(1), 64'd0, '0);
    chk("status_rd", rc_data, 64'h4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, ad(0), 64'd0, '0);

    // counter wrap
    step(1'b1, 1'b0, ad(5), 64'hFFFF_FFFF_FFFF_FFFE, '0);
    step(1'b0, 1'b0, ad(0), 64'd0, '0);
    step(1'b0, 1'b1, ad(5), 64'd0, '0);
    chk("cnt_max", rc_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b1, ad(5), 64'd0, '0);
    chk("cnt_wrap", rc_data, 64'd0);

    // reset in holdoff while a completion is showing
    step(1'b1, 1'b0, ad(2), 64'h4, '0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b1, ad(0), 64'd0, '0);
      found = interrupt_out;
    end
    chk("pulse_seen", 64'(found), 64'd1);
    chk("pre_rst_done", 64'(rc_done), 64'd1);
    rr_valid = 1'b1;
    reset    = 1'b1;
    #1;
    chk("async_irq", 64'(interrupt_out), 64'd0);
    chk("async_done", 64'(rc_done), 64'd0);
    chk("async_data", rc_data, 64'd0);
    chk("async_status", 64'(int_status), 64'd0);
    @(posedge clock);
    #1;
    chk("no_cpl", 64'(rc_done), 64'd0);
    rr_valid = 1'b0;
    reset    = 1'b0;
    m_reset();
    step(1'b0, 1'b1, ad(1), 64'd0, '0);
    step(1'b0, 1'b1, ad(2), 64'd0, '0);
    step(1'b0, 1'b1, ad(3), 64'd0, '0);
    chk("hold_rst", rc_data, 64'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      o  = int'($urandom_range(0, 7));
      ra = ($urandom_range(0, 9) == 0)
           ? {10'($urandom_range(1, 1023)), 3'(o)} : ad(o);
      rw = {$urandom, $urandom};
      if (o == 3) rw = 64'($urandom_range(0, 6));
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           ra, rw,
           ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
